fp_add_arbiter: RTL and testbench

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

---
 rtl/fp_add_arbiter.sv | 186 ++++++++++++++++++
 tb/tb_fp_add_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// fp_add_arbiter
//
// Shares one external two-input floating-point adder among four requesters,
// one operation at a time. Requests are granted round-robin, starting just
// after the most recently granted requester. The winner's operands are
// latched and held on the adder inputs. When the adder signals done, or the
// TIMEOUT budget runs out, a one-cycle ack is returned to the winner. The
// block never looks inside the operands or the sum.
//
// Ports
//   CLK        in   1    clock, rising edge
//   reset      in   1    synchronous active-low reset
//   req        in   4    request level, bit i = requester i
//   opa, opb   in   128  operands, requester i on bits [32i+31:32i]
//   ack        out  4    one-cycle completion pulse to the granted requester
//   result     out  32   sum of the acknowledged operation (0 on timeout)
//   err        out  1    high with ack when the operation timed out
//   busy       out  1    high whenever the state is not IDLE
//   add_dataa  out  32   operand A to the shared adder
//   add_datab  out  32   operand B to the shared adder
//   add_go     out  1    adder active-low reset: 1 = run, 0 = hold cleared
//   add_result in   32   adder sum
//   add_done   in   1    adder completion level, looked at only in BUSY
// ---------------------------------------------------------------------------
module fp_add_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic         CLK,
    input  logic         reset,
    input  logic [3:0]   req,
    input  logic [127:0] opa,
    input  logic [127:0] opb,
    output logic [3:0]   ack,
    output logic [31:0]  result,
    output logic         err,
    output logic         busy,
    output logic [31:0]  add_dataa,
    output logic [31:0]  add_datab,
    output logic         add_go,
    input  logic [31:0]  add_result,
    input  logic         add_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Counter value seen on the last BUSY cycle the adder is allowed.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t      state_q,  state_d;
    logic [1:0]  idx_q,    idx_d;
    logic [1:0]  last_q,   last_d;
    logic [7:0]  cnt_q,    cnt_d;
    logic [3:0]  ack_q,    ack_d;
    logic        err_q,    err_d;
    logic [31:0] result_q, result_d;
    logic [31:0] dataa_q,  dataa_d;
    logic [31:0] datab_q,  datab_d;
    logic        go_q,     go_d;

    // Unpack the per-requester operand slices.
    logic [31:0] opa_w [4];
    logic [31:0] opb_w [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign opa_w[gi] = opa[32*gi +: 32];
            assign opb_w[gi] = opb[32*gi +: 32];
        end
    endgenerate

    // Round-robin pick: scan offsets 4 down to 1 from last_q so the smallest
    // offset that has a request is the final one written. Offset 4 is
    // last_q itself, which therefore has the lowest priority.
    logic       grant_valid;
    logic [1:0] grant_idx;

    always_comb begin
        logic [1:0] cand;
        grant_valid = 1'b0;
        grant_idx   = last_q;
        cand        = last_q;
        for (int k = 4; k >= 1; k--) begin
            cand = last_q + 2'(k);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        last_d   = last_q;
        cnt_d    = cnt_q;
        ack_d    = 4'b0000;
        err_d    = 1'b0;
        result_d = result_q;
        dataa_d  = dataa_q;
        datab_d  = datab_q;
        go_d     = go_q;

        case (state_q)
            IDLE: begin
                go_d = 1'b0;
                if (grant_valid) begin
                    idx_d   = grant_idx;
                    last_d  = grant_idx;
                    dataa_d = opa_w[grant_idx];
                    datab_d = opb_w[grant_idx];
                    cnt_d   = 8'd0;
                    go_d    = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                go_d  = 1'b1;
                cnt_d = cnt_q + 8'd1;
                // A done on the final allowed cycle still counts as success.
                if (add_done) begin
                    result_d = add_result;
                    ack_d    = 4'b0001 << idx_q;
                    go_d     = 1'b0;
                    state_d  = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    result_d = 32'd0;
                    ack_d    = 4'b0001 << idx_q;
                    err_d    = 1'b1;
                    go_d     = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                // Single cycle with the adder held cleared; ack_d/err_d
                // default to 0 so the pulse ends on the way out.
                go_d    = 1'b0;
                state_d = IDLE;
            end
            default: begin
                go_d    = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!reset) begin
            state_q  <= IDLE;
            idx_q    <= 2'd0;
            last_q   <= 2'd3;
            cnt_q    <= 8'd0;
            ack_q    <= 4'b0000;
            err_q    <= 1'b0;
            result_q <= 32'd0;
            dataa_q  <= 32'd0;
            datab_q  <= 32'd0;
            go_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            last_q   <= last_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            err_q    <= err_d;
            result_q <= result_d;
            dataa_q  <= dataa_d;
            datab_q  <= datab_d;
            go_q     <= go_d;
        end
    end

    assign ack       = ack_q;
    assign err       = err_q;
    assign result    = result_q;
    assign busy      = (state_q != IDLE);
    assign add_dataa = dataa_q;
    assign add_datab = datab_q;
    assign add_go    = go_q;

endmodule

// File: tb/tb_fp_add_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fp_add_arbiter
//
// Directed bench for fp_add_arbiter. A behavioural adder raises done a
// programmable number of cycles after add_go rises (0 = never). Expected
// completions are queued when a request is driven. A monitor pops and checks
// every ack. The directed sequence checks latency, round-robin order,
// timeout and reset behaviour.
// ---------------------------------------------------------------------------
module tb_fp_add_arbiter;

    localparam int TIMEOUT = 16;

    logic         CLK = 1'b0;
    logic         reset = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [127:0] opa = '0;
    logic [127:0] opb = '0;
    logic [3:0]   ack;
    logic [31:0]  result;
    logic         err;
    logic         busy;
    logic [31:0]  add_dataa;
    logic [31:0]  add_datab;
    logic         add_go;
    logic [31:0]  add_result;
    logic         add_done;

    int   n_vec = 0;
    int   n_err = 0;
    int   done_dly = 3;
    logic done_force = 1'b0;
    int   mcnt = 0;
    int   cyc_ctr = 0;
    logic mon_en = 1'b0;

    typedef struct packed {
        logic [3:0]  exp_ack;
        logic [31:0] exp_res;
        logic        exp_err;
    } exp_t;

    exp_t sb [$];

    always #5 CLK = ~CLK;

    fp_add_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .CLK        (CLK),
        .reset      (reset),
        .req        (req),
        .opa        (opa),
        .opb        (opb),
        .ack        (ack),
        .result     (result),
        .err        (err),
        .busy       (busy),
        .add_dataa  (add_dataa),
        .add_datab  (add_datab),
        .add_go     (add_go),
        .add_result (add_result),
        .add_done   (add_done)
    );

    // ---------------- behavioural single-precision adder ----------------
    // Handles zero and normal numbers, which is all the bench feeds it.
    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:0] == 31'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] b;
        logic [10:0] e;
        b = $realtobits(r);
        if (b[62:0] == 63'd0) return {b[63], 31'd0};
        e = b[62:52] - 11'd896;
        return {b[63], e[7:0], b[51:29]};
    endfunction

    function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    always @(posedge CLK) begin
        cyc_ctr <= cyc_ctr + 1;
        if (!add_go) mcnt <= 0;
        else         mcnt <= mcnt + 1;
    end

    assign add_done = done_force | (add_go && (done_dly != 0) && (mcnt >= done_dly - 1));

    always_comb add_result = fp_add(add_dataa, add_datab);

    // ---------------- checking helpers ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_vec++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input logic [3:0] a, input logic [31:0] r, input logic e);
        exp_t t;
        t.exp_ack = a;
        t.exp_res = r;
        t.exp_err = e;
        sb.push_back(t);
    endtask

    task automatic set_ops(input int i, input logic [31:0] a, input logic [31:0] b);
        opa[32*i +: 32] = a;
        opb[32*i +: 32] = b;
    endtask

    // Counts rising edges from the call until ack is seen; returns -1 if the
    // bound runs out. Called just after req is driven in IDLE, so the count
    // includes the grant edge and equals grant-to-ack-edge latency.
    task automatic wait_ack(output int n);
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
            if (ack != 4'b0000) return;
        end
        n = -1;
    endtask

    task automatic drop_req(input int i);
        @(posedge CLK);
        #1;
        req[i] = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (mon_en && ack !== 4'b0000) begin
            chk("ack_onehot", {31'd0, $onehot0(ack)}, 32'd1);
            if (sb.size() == 0) begin
                chk("unexpected_ack", {28'd0, ack}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("ack=%b result=%h err=%b (expected ack=%b result=%h err=%b)",
                         ack, result, err, e.exp_ack, e.exp_res, e.exp_err);
                chk("sb_ack", {28'd0, ack}, {28'd0, e.exp_ack});
                chk("sb_result", result, e.exp_res);
                chk("sb_err", {31'd0, err}, {31'd0, e.exp_err});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int prev_t;

        // Reset state
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        chk("rst_ack", {28'd0, ack}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_go", {31'd0, add_go}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_dataa", add_dataa, 32'd0);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        mon_en = 1'b1;

        // 1.0 + 2.0 on requester 0, done 3 cycles after add_go rises
        done_dly = 3;
        set_ops(0, 32'h3F800000, 32'h40000000);
        push_exp(4'b0001, 32'h40400000, 1'b0);
        req = 4'b0001;
        @(posedge CLK);
        #1;
        opa[31:0] = 32'hDEADBEEF;          // must not disturb the latched operand
        @(negedge CLK);
        chk("busy_go", {31'd0, add_go}, 32'd1);
        chk("busy_flag", {31'd0, busy}, 32'd1);
        chk("latched_a", add_dataa, 32'h3F800000);
        chk("latched_b", add_datab, 32'h40000000);
        wait_ack(n);
        chk("lat_L3", n + 1, 32'd4);
        chk("resp_go", {31'd0, add_go}, 32'd0);
        chk("resp_busy", {31'd0, busy}, 32'd1);
        drop_req(0);
        @(negedge CLK);
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_ack", {28'd0, ack}, 32'd0);
        chk("result_hold", result, 32'h40400000);

        // Fresh reset, then all four requesters held
        @(posedge CLK);
        #1;
        reset = 1'b0;
        @(posedge CLK);
        #1;
        reset = 1'b1;
        set_ops(0, 32'h3F800000, 32'h3F000000);
        set_ops(1, 32'h40000000, 32'h3F800000);
        set_ops(2, 32'h40400000, 32'hBF800000);
        set_ops(3, 32'h40800000, 32'h40000000);
        push_exp(4'b0001, 32'h3FC00000, 1'b0);
        push_exp(4'b0010, 32'h40400000, 1'b0);
        push_exp(4'b0100, 32'h40000000, 1'b0);
        push_exp(4'b1000, 32'h40C00000, 1'b0);
        req = 4'b1111;
        prev_t = 0;
        for (int i = 0; i < 4; i++) begin
            wait_ack(n);
            chk("rr_wait", n, 32'd4);
            chk("rr_order", {28'd0, ack}, 32'd1 << i);
            if (i > 0) chk("rr_spacing", cyc_ctr - prev_t, 32'd5);
            prev_t = cyc_ctr;
            drop_req(i);
        end

        // Serve requester 2, then 0101 wraps to requester 0 before 2
        push_exp(4'b0100, 32'h40000000, 1'b0);
        req = 4'b0100;
        wait_ack(n);
        chk("r2_wait", n, 32'd4);
        drop_req(2);
        push_exp(4'b0001, 32'h3FC00000, 1'b0);
        push_exp(4'b0100, 32'h40000000, 1'b0);
        req = 4'b0101;
        wait_ack(n);
        chk("wrap_first", {28'd0, ack}, 32'b0001);
        drop_req(0);
        wait_ack(n);
        chk("wrap_second", {28'd0, ack}, 32'b0100);
        drop_req(2);

        // Adder never finishes: timeout on BUSY cycle TIMEOUT
        done_dly = 0;
        push_exp(4'b0010, 32'd0, 1'b1);
        req = 4'b0010;
        wait_ack(n);
        chk("tmo_wait", n, TIMEOUT + 1);
        chk("tmo_go", {31'd0, add_go}, 32'd0);
        drop_req(1);
        done_dly = 3;
        push_exp(4'b0010, 32'h40400000, 1'b0);
        req = 4'b0010;
        wait_ack(n);
        chk("post_tmo_wait", n, 32'd4);
        drop_req(1);

        // Done arrives exactly on the timeout cycle: success wins
        done_dly = TIMEOUT;
        push_exp(4'b1000, 32'h40C00000, 1'b0);
        req = 4'b1000;
        wait_ack(n);
        chk("edge_wait", n, TIMEOUT + 1);
        drop_req(3);

        // Reset during BUSY cycle 2 aborts without an ack
        done_dly = 0;
        req = 4'b0001;
        @(posedge CLK);                 // grant edge
        @(posedge CLK);                 // now in BUSY cycle 2
        #1;
        reset = 1'b0;
        req = 4'b0000;
        @(negedge CLK);
        chk("abort_pre_busy", {31'd0, busy}, 32'd1);
        @(posedge CLK);
        #1;
        reset = 1'b1;
        @(negedge CLK);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        chk("abort_go", {31'd0, add_go}, 32'd0);
        chk("abort_ack", {28'd0, ack}, 32'd0);
        chk("abort_result", result, 32'd0);
        chk("abort_dataa", add_dataa, 32'd0);
        done_force = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk("late_done_ack", {28'd0, ack}, 32'd0);
        end
        @(posedge CLK);
        #1;
        done_force = 1'b0;

        // After reset last = 3, so 1001 grants 0 before 3
        done_dly = 3;
        push_exp(4'b0001, 32'h3FC00000, 1'b0);
        push_exp(4'b1000, 32'h40C00000, 1'b0);
        req = 4'b1001;
        wait_ack(n);
        chk("post_rst_first", {28'd0, ack}, 32'b0001);
        drop_req(0);
        wait_ack(n);
        chk("post_rst_second", {28'd0, ack}, 32'b1000);
        drop_req(3);

        repeat (3) @(negedge CLK);
        chk("sb_drained", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
